// File: rtl/ccip_mmio_responder.sv
// CCI-P MMIO target: decodes MMIO reads/writes against DFH, AFU ID and scratch CSRs and
// returns read responses in order through a credit-protected response FIFO.
module ccip_mmio_responder #(
  parameter logic [127:0] AFU_ID         = '0,
  parameter logic [63:0]  DFH_VALUE      = '0,
  parameter int           NUM_SCRATCH    = 4,
  parameter int           RSP_FIFO_DEPTH = 8
) (
  input  logic        vl_clk_LPdomain_16ui,
  input  logic        ffs_LP16ui_afu_SoftReset_n,
  input  logic        rx_mmio_rd_valid,
  input  logic        rx_mmio_wr_valid,
  input  logic [15:0] rx_mmio_addr,
  input  logic [1:0]  rx_mmio_len,
  input  logic [8:0]  rx_mmio_tid,
  input  logic [63:0] rx_mmio_wrdata,
  input  logic        tx_rsp_ready,
  output logic        tx_rsp_valid,
  output logic [8:0]  tx_rsp_tid,
  output logic [63:0] tx_rsp_data,
  output logic        afu_error
);

  localparam int          PTR_W        = $clog2(RSP_FIFO_DEPTH);
  localparam logic [14:0] SCRATCH_BASE = 15'd5;  // byte 0x028 / 8

  typedef struct packed {
    logic [8:0]  tid;
    logic [63:0] data;
  } rsp_t;

  logic clk;
  logic rst_n;
  assign clk   = vl_clk_LPdomain_16ui;
  assign rst_n = ffs_LP16ui_afu_SoftReset_n;

  logic [63:0]      scratch [NUM_SCRATCH];
  logic             s1_valid;
  logic [8:0]       s1_tid;
  logic [15:0]      s1_addr;
  logic             s1_len8;
  rsp_t             fifo_mem [RSP_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  rsp_t             last_rsp;
  rsp_t             head;

  logic        len_bad;
  logic        misaligned;
  logic        fmt_err;
  logic        wr_ok;
  logic        rd_ok;
  logic        credit_ok;
  logic        rd_accept;
  logic        err_set;
  logic        push;
  logic        pop;
  logic [63:0] rd_reg;
  logic [63:0] rd_data;

  assign push = s1_valid;
  assign pop  = tx_rsp_valid;
  assign head = fifo_mem[rd_ptr];

  // Reset gates the output so a queued response is never sent in the reset cycle.
  assign tx_rsp_valid = rst_n && tx_rsp_ready && (count != '0);
  assign tx_rsp_tid   = tx_rsp_valid ? head.tid  : last_rsp.tid;
  assign tx_rsp_data  = tx_rsp_valid ? head.data : last_rsp.data;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    len_bad    = rx_mmio_len[1];
    misaligned = (rx_mmio_len == 2'd1) && rx_mmio_addr[0];
    fmt_err    = (rx_mmio_rd_valid || rx_mmio_wr_valid) && (len_bad || misaligned);
    wr_ok      = rx_mmio_wr_valid && !len_bad && !misaligned;
    rd_ok      = rx_mmio_rd_valid && !rx_mmio_wr_valid && !len_bad && !misaligned;
    // The read in stage1 already owns a FIFO slot; a pop this cycle frees one.
    credit_ok  = (int'(count) + int'(s1_valid) - int'(pop)) < RSP_FIFO_DEPTH;
    rd_accept  = rd_ok && credit_ok;
    err_set    = fmt_err || (rx_mmio_rd_valid && rx_mmio_wr_valid) || (rd_ok && !credit_ok);
  end

  // Stage2: CSR read mux on the registered request.
  always_comb begin
    rd_reg = '0;
    case (s1_addr[15:1])
      15'd0:   rd_reg = DFH_VALUE;
      15'd1:   rd_reg = AFU_ID[63:0];
      15'd2:   rd_reg = AFU_ID[127:64];
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (s1_addr[15:1] == SCRATCH_BASE + 15'(i)) rd_reg = scratch[i];
        end
      end
    endcase
    if (s1_len8)         rd_data = rd_reg;
    else if (s1_addr[0]) rd_data = {32'h0, rd_reg[63:32]};
    else                 rd_data = {32'h0, rd_reg[31:0]};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_tid    <= '0;
      s1_addr   <= '0;
      s1_len8   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_rsp  <= '0;
      afu_error <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
    end else begin
      s1_valid <= rd_accept;
      if (rd_accept) begin
        s1_tid  <= rx_mmio_tid;
        s1_addr <= rx_mmio_addr;
        s1_len8 <= rx_mmio_len[0];
      end

      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (wr_ok && rx_mmio_addr[15:1] == SCRATCH_BASE + 15'(i)) begin
          if (rx_mmio_len[0])       scratch[i]        <= rx_mmio_wrdata;
          else if (rx_mmio_addr[0]) scratch[i][63:32] <= rx_mmio_wrdata[31:0];
          else                      scratch[i][31:0]  <= rx_mmio_wrdata[31:0];
        end
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_rsp <= head;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (err_set) afu_error <= 1'b1;
    end
  end

  // NOTE: FIFO storage is not reset; entries are only visible through count, which is.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{tid: s1_tid, data: rd_data};
  end

endmodule

// File: tb/tb_ccip_mmio_responder.sv
// Bench for ccip_mmio_responder: directed scenarios plus random traffic checked against a
// transaction-level model (CSR map, in-order response queue with 2-cycle latency, credit limit).
module tb_ccip_mmio_responder;

  localparam logic [127:0] AFU_ID  = 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_EEFF;
  localparam logic [63:0]  DFH     = 64'h1000_0000_0000_0A5A;
  localparam int           NSCR    = 4;
  localparam int           DEPTH   = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_valid, wr_valid;
  logic [15:0] addr;
  logic [1:0]  len;
  logic [8:0]  tid;
  logic [63:0] wrdata;
  logic        ready;
  logic        tx_rsp_valid;
  logic [8:0]  tx_rsp_tid;
  logic [63:0] tx_rsp_data;
  logic        afu_error;

  always #5 clk = ~clk;

  ccip_mmio_responder #(
    .AFU_ID(AFU_ID), .DFH_VALUE(DFH), .NUM_SCRATCH(NSCR), .RSP_FIFO_DEPTH(DEPTH)
  ) dut (
    .vl_clk_LPdomain_16ui      (clk),
    .ffs_LP16ui_afu_SoftReset_n(rst_n),
    .rx_mmio_rd_valid          (rd_valid),
    .rx_mmio_wr_valid          (wr_valid),
    .rx_mmio_addr              (addr),
    .rx_mmio_len               (len),
    .rx_mmio_tid               (tid),
    .rx_mmio_wrdata            (wrdata),
    .tx_rsp_ready              (ready),
    .tx_rsp_valid              (tx_rsp_valid),
    .tx_rsp_tid                (tx_rsp_tid),
    .tx_rsp_data               (tx_rsp_data),
    .afu_error                 (afu_error)
  );

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          due;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          n_rsp = 0;
  exp_t        q[$];
  logic [63:0] m_scr [NSCR];
  logic        m_err;
  logic [8:0]  m_last_tid;
  logic [63:0] m_last_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model_reg(input logic [15:0] a);
    int idx = int'(a >> 1);
    if (idx == 0) return DFH;
    if (idx == 1) return AFU_ID[63:0];
    if (idx == 2) return AFU_ID[127:64];
    if (idx >= 5 && idx < 5 + NSCR) return m_scr[idx-5];
    return 64'h0;
  endfunction

  function automatic logic [63:0] model_read(input logic [15:0] a, input logic [1:0] l);
    logic [63:0] r = model_reg(a);
    if (l == 2'd1) return r;
    return a[0] ? {32'h0, r[63:32]} : {32'h0, r[31:0]};
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < NSCR; i++) m_scr[i] = '0;
    m_err       = 1'b0;
    m_last_tid  = '0;
    m_last_data = '0;
  endtask

  // One clock cycle: drive request, check outputs of this cycle, advance the model.
  task automatic step(input logic r, input logic rd, input logic wr, input logic [15:0] a,
                      input logic [1:0] l, input logic [8:0] t, input logic [63:0] wd,
                      input logic rdy);
    logic exp_v;
    logic bad;
    exp_t e;
    int   idx;
    @(negedge clk);
    rst_n = r; rd_valid = rd; wr_valid = wr; addr = a; len = l; tid = t; wrdata = wd;
    ready = rdy;
    #1;
    exp_v = r && rdy && (q.size() > 0) && (q[0].due <= cyc);
    check("valid", {63'h0, tx_rsp_valid}, {63'h0, exp_v});
    check("afu_error", {63'h0, afu_error}, {63'h0, m_err});
    if (tx_rsp_valid === 1'b1) n_rsp++;
    if (exp_v) begin
      e = q.pop_front();
      check("rsp_tid", {55'h0, tx_rsp_tid}, {55'h0, e.tid});
      check("rsp_data", tx_rsp_data, e.data);
      m_last_tid  = e.tid;
      m_last_data = e.data;
    end else begin
      check("hold_tid", {55'h0, tx_rsp_tid}, {55'h0, m_last_tid});
      check("hold_data", tx_rsp_data, m_last_data);
    end
    if (!r) begin
      model_reset();
    end else begin
      bad = (rd || wr) && (l[1] || (l == 2'd1 && a[0]));
      if (bad || (rd && wr)) m_err = 1'b1;
      if (rd && !wr && !bad) begin
        if (q.size() >= DEPTH) m_err = 1'b1;
        else q.push_back('{tid: t, data: model_read(a, l), due: cyc + 2});
      end
      if (wr && !bad) begin
        idx = int'(a >> 1) - 5;
        if (idx >= 0 && idx < NSCR) begin
          if (l == 2'd1)  m_scr[idx]        = wd;
          else if (a[0])  m_scr[idx][63:32] = wd[31:0];
          else            m_scr[idx][31:0]  = wd[31:0];
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 2'd0, 9'h0, 64'h0, rdy);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 9'h0, 64'h0, 1'b1);
  endtask

  int          base;
  logic [15:0] ra;
  logic [1:0]  rl;
  logic        rrd, rwr;

  initial begin
    rst_n = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0; addr = '0; len = '0; tid = '0;
    wrdata = '0; ready = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();

    // T1: AFU_ID low read, response two cycles later
    base = n_rsp;
    step(1'b1, 1'b1, 1'b0, 16'h0002, 2'd1, 9'h005, 64'h0, 1'b1);
    idle(3, 1'b1);
    check("t1_rsp_count", 64'(n_rsp - base), 64'd1);

    // T2: 8B write then next-cycle 4B read of high half
    step(1'b1, 1'b0, 1'b1, 16'h000A, 2'd1, 9'h0, 64'hDEADBEEF_CAFEF00D, 1'b1);
    step(1'b1, 1'b1, 1'b0, 16'h000B, 2'd0, 9'h1FF, 64'h0, 1'b1);
    idle(3, 1'b1);
    check("t2_last_data", tx_rsp_data, 64'h00000000_DEADBEEF);

    // T3: eight queued reads under backpressure, drained in order
    base = n_rsp;
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 1'b0, 16'(2 * (i % 9)), 2'd1, 9'(i), 64'h0, 1'b0);
    idle(3, 1'b0);
    idle(12, 1'b1);
    check("t3_rsp_count", 64'(n_rsp - base), 64'd8);

    // T4: ninth read overflows the credit budget
    do_reset();
    base = n_rsp;
    for (int i = 0; i < 9; i++)
      step(1'b1, 1'b1, 1'b0, 16'h000A, 2'd1, 9'(i + 32), 64'h0, 1'b0);
    idle(3, 1'b0);
    idle(12, 1'b1);
    check("t4_rsp_count", 64'(n_rsp - base), 64'd8);

    // T5: misaligned 8B read, then reset clears error and scratch
    do_reset();
    step(1'b1, 1'b0, 1'b1, 16'h000C, 2'd1, 9'h0, 64'h1234_5678_9ABC_DEF0, 1'b1);
    base = n_rsp;
    step(1'b1, 1'b1, 1'b0, 16'h0003, 2'd1, 9'h033, 64'h0, 1'b1);
    idle(4, 1'b1);
    check("t5_no_rsp", 64'(n_rsp - base), 64'd0);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 16'h000C, 2'd1, 9'h034, 64'h0, 1'b1);
    idle(3, 1'b1);
    check("t5_scratch_cleared", tx_rsp_data, 64'h0);

    // T6: queued reads dropped by reset; fresh read served normally
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 16'h0000, 2'd1, 9'(i + 64), 64'h0, 1'b0);
    idle(2, 1'b0);
    do_reset();
    base = n_rsp;
    idle(4, 1'b1);
    check("t6_no_stale", 64'(n_rsp - base), 64'd0);
    step(1'b1, 1'b1, 1'b0, 16'h0004, 2'd0, 9'h010, 64'h0, 1'b1);
    idle(3, 1'b1);
    check("t6_new_rsp", 64'(n_rsp - base), 64'd1);

    // Random traffic with occasional resets
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        ra  = ($urandom_range(0, 19) == 0) ? 16'($urandom) : 16'($urandom_range(0, 25));
        rl  = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
        if (rl == 2'd1 && $urandom_range(0, 19) != 0) ra[0] = 1'b0;
        rrd = ($urandom_range(0, 99) < 45);
        rwr = ($urandom_range(0, 99) < (rrd ? 2 : 35));
        step(1'b1, rrd, rwr, ra, rl, 9'($urandom), {$urandom, $urandom},
             ($urandom_range(0, 99) < 60));
      end
    end

    idle(DEPTH + 6, 1'b1);
    check("drain_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
